cpu_ctrl_fsm: RTL and testbench
===============================

// Module: cpu_ctrl_fsm
// PURPOSE
// Multi-cycle control unit that drives the reg_alu datapath. It fetches 16-bit instructions
// over a req/ack memory port and decodes them into the reg_alu control set (write, IMM_MUX,
// WB_MUX, rSrc, rDst, aluOp, imm, pc1). It sequences LOAD/STOR data accesses, evaluates
// Bcond against reg_alu psrOut and owns the program counter.
// PARAMETERS
// RESET_PC  16'h0000  PC value loaded on reset
// PORTS
// clk        in   1   clock
// rst        in   1   synchronous active-high reset
// mem_ack    in   1   memory access complete; rdata valid this cycle
// mem_rdata  in   16  instruction (FETCH) or load data (MEM)
// psrOut     in   5   flags from reg_alu {L,Z,F,N,C} = bits [4:0]
// dSrc       in   16  reg_alu source-operand read data (LOAD/STOR address)
// dDst       in   16  reg_alu destination-operand read data (STOR write data)
// mem_req    out  1   memory request, held until mem_ack
// mem_we     out  1   write strobe, valid with mem_req
// mem_addr   out  16  PC in FETCH, dSrc in MEM
// mem_wdata  out  16  dDst
// write      out  1   register-file write enable
// IMM_MUX    out  1   1 = imm drives ALU B operand
// WB_MUX     out  2   2'b10 ALU, 2'b11 mem_data, 2'b01 pc1
// rSrc       out  4   source register index
// rDst       out  4   destination register index
// aluOp      out  5   ALU operation (`ALUOp_* macros in defines.v)
// imm        out  16  extended immediate
// pc1        out  16  pc + 1
// mem_data   out  16  mem_rdata registered for LOAD write-back
// illegal    out  1   one-cycle pulse on an undecodable instruction
// BEHAVIOUR
// - Reset: state=FETCH, pc=RESET_PC, ir=16'h0000, mem_data=0.
// - Reset: control outputs are in the idle set: mem_req=0, mem_we=0, write=0, IMM_MUX=0,
//   WB_MUX=2'b10, rSrc=0, rDst=0, aluOp=0, imm=0, illegal=0.
// - Reset wins over every other event, including a pending mem_ack.
// - FETCH: mem_req=1, mem_addr=pc. On mem_ack: ir<=mem_rdata, go to EXEC.
// - EXEC, one cycle. Decode fields: op=ir[15:12], rd=ir[11:8], ext=ir[7:4], rs=ir[3:0].
//   rDst=rd; rSrc=rs.
//   * op 0x0 R-type: ext 1 AND, 5 ADD, 9 SUB, B CMP, D MOV. write=1 except for CMP.
//   * op 1/5/9/B/D: immediate forms of the R-type ops. IMM_MUX=1.
//     ADDI/SUBI/CMPI: imm = sign-extended ir[7:0]. ANDI/MOVI: imm = zero-extended ir[7:0].
//   * op 0xF LUI: imm = zero-extended ir[7:0], aluOp=`ALUOp_LUI, write=1.
//   * op 0x8 shift: ext 0 SLL, ext 1 SRA. imm = {12'b0, ir[3:0]}, IMM_MUX=1, write=1.
//   * op 0x4 ext 0 LOAD, ext 4 STOR: go to MEM. pc is not updated until MEM completes.
//   * op 0xC Bcond: cond=ir[11:8], disp=sext(ir[7:0]).
//     Conditions: 0 EQ(Z), 1 NE(!Z), 4 HS(!L), 5 LO(L), C GE(!N), D LT(N), E UC(1).
//     Other cond values are never taken. Taken: pc<=pc+1+disp. Not taken: pc<=pc+1.
//     write=0.
//   * Every other encoding: illegal=1 and the instruction executes as a NOP (pc<=pc+1).
//   * Non-branch, non-memory instructions: pc<=pc+1, next state FETCH.
// - MEM: mem_req=1, mem_addr=dSrc, rSrc=rs, rDst=rd. mem_we=1 for STOR.
//   * On mem_ack: mem_data<=mem_rdata, pc<=pc+1, go to WB for LOAD, FETCH for STOR.
// - WB (LOAD only): write=1, WB_MUX=2'b11, rDst=rd, then FETCH.
// - Latency: ALU/branch = fetch wait + 2 cycles; LOAD = fetch + mem wait + 3; STOR = +2.
// - mem_req stays high and mem_addr stays stable until mem_ack.
// - mem_ack while mem_req=0 is ignored.
// - pc arithmetic is 16-bit modulo: 16'hFFFF+1 wraps to 0, and branch targets wrap the same way.
// - write is asserted for exactly one cycle per register-writing instruction.
// CONFIGURATION
// - CPU_CTRL_JAL_EN defined: op 0x4 ext 8 is JAL rd, rs.
//   EXEC: write=1, WB_MUX=2'b01 (rd<=pc1), pc<=dSrc.
// - CPU_CTRL_JAL_EN undefined: the same encoding pulses illegal and executes as a NOP.
// TESTING
// - rst high 3 cycles, then release -> first mem_req=1 with mem_addr=RESET_PC;
//   all outputs idle during reset.
// - Fetch 16'h510A (ADDI r1,10) with ack after 2 waits -> EXEC: write=1, IMM_MUX=1, rDst=1,
//   imm=16'h000A, aluOp=`ALUOp_ADD; pc 0->1.
// - Fetch 16'h4302 (LOAD r3,r2) with dSrc=16'hFF00, load rdata=16'h000A
//   -> mem_addr=16'hFF00, mem_we=0; then WB: write=1, WB_MUX=2'b11, rDst=3, mem_data=16'h000A.
// - Fetch 16'h4142 (STOR r1,r2) with dDst=16'h000A -> mem_we=1, mem_wdata=16'h000A,
//   mem_addr=dSrc; write never asserted.
// - Bcond 16'hC0FE (EQ, disp -2) at pc=16'h0010: psrOut Z=1 -> pc=16'h000F;
//   Z=0 -> pc=16'h0011. At pc=16'hFFFF with UC disp 0 -> pc=0.
// - 16'h7000 -> illegal pulses 1 cycle, no write, pc+1.
//   Assert rst mid-MEM -> next cycle FETCH, mem_req=0, pc=RESET_PC.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control unit for the reg_alu datapath.
// Fetches 16-bit instructions over a req/ack memory port, decodes them into
// the reg_alu control set, sequences LOAD/STOR data accesses, evaluates
// branch conditions against psrOut and owns the program counter.
// Optional feature: define CPU_CTRL_JAL_EN to decode op 0x4 ext 0x8 as JAL;
// without it that encoding is reported as illegal and runs as a NOP.
module cpu_ctrl_fsm #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic [4:0]  psrOut,
    input  logic [15:0] dSrc,
    input  logic [15:0] dDst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        write,
    output logic        IMM_MUX,
    output logic [1:0]  WB_MUX,
    output logic [3:0]  rSrc,
    output logic [3:0]  rDst,
    output logic [4:0]  aluOp,
    output logic [15:0] imm,
    output logic [15:0] pc1,
    output logic [15:0] mem_data,
    output logic        illegal
);

    // ALU operation codes shared with reg_alu
    localparam logic [4:0] ALUOP_NOP = 5'h00;
    localparam logic [4:0] ALUOP_AND = 5'h01;
    localparam logic [4:0] ALUOP_ADD = 5'h05;
    localparam logic [4:0] ALUOP_SUB = 5'h09;
    localparam logic [4:0] ALUOP_CMP = 5'h0B;
    localparam logic [4:0] ALUOP_MOV = 5'h0D;
    localparam logic [4:0] ALUOP_LUI = 5'h0F;
    localparam logic [4:0] ALUOP_SLL = 5'h10;
    localparam logic [4:0] ALUOP_SRA = 5'h11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] mem_data_q, mem_data_d;

    // Instruction fields
    logic [3:0]  op, rd, ext, rs;
    logic [15:0] imm_sext, imm_zext;
    logic [15:0] pc_inc;
    logic        branch_taken;

    // Flags F and C are not used by any branch condition
    logic unused_flags;
    assign unused_flags = psrOut[2] ^ psrOut[0];

    assign op       = ir_q[15:12];
    assign rd       = ir_q[11:8];
    assign ext      = ir_q[7:4];
    assign rs       = ir_q[3:0];
    assign imm_sext = {{8{ir_q[7]}}, ir_q[7:0]};
    assign imm_zext = {8'h00, ir_q[7:0]};
    assign pc_inc   = pc_q + 16'd1;

    assign pc1       = pc_inc;
    assign mem_wdata = dDst;
    assign mem_data  = mem_data_q;

    // Branch condition evaluation on psrOut {L,Z,F,N,C}
    always_comb begin
        branch_taken = 1'b0;
        case (rd)
            4'h0:    branch_taken = psrOut[3];
            4'h1:    branch_taken = ~psrOut[3];
            4'h4:    branch_taken = ~psrOut[4];
            4'h5:    branch_taken = psrOut[4];
            4'hC:    branch_taken = ~psrOut[1];
            4'hD:    branch_taken = psrOut[1];
            4'hE:    branch_taken = 1'b1;
            default: branch_taken = 1'b0;
        endcase
    end

    // State register, program counter, instruction and load-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= 16'h0000;
            mem_data_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Next-state, next-PC and control-output decode
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        mem_data_d = mem_data_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc_q;
        write      = 1'b0;
        IMM_MUX    = 1'b0;
        WB_MUX     = 2'b10;
        rSrc       = 4'h0;
        rDst       = 4'h0;
        aluOp      = ALUOP_NOP;
        imm        = 16'h0000;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                rDst    = rd;
                rSrc    = rs;
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (op)
                    4'h0: begin
                        case (ext)
                            4'h1: begin aluOp = ALUOP_AND; write = 1'b1; end
                            4'h5: begin aluOp = ALUOP_ADD; write = 1'b1; end
                            4'h9: begin aluOp = ALUOP_SUB; write = 1'b1; end
                            4'hB: begin aluOp = ALUOP_CMP; end
                            4'hD: begin aluOp = ALUOP_MOV; write = 1'b1; end
                            default: illegal = 1'b1;
                        endcase
                    end
                    4'h1: begin aluOp = ALUOP_AND; IMM_MUX = 1'b1; imm = imm_zext; write = 1'b1; end
                    4'h5: begin aluOp = ALUOP_ADD; IMM_MUX = 1'b1; imm = imm_sext; write = 1'b1; end
                    4'h9: begin aluOp = ALUOP_SUB; IMM_MUX = 1'b1; imm = imm_sext; write = 1'b1; end
                    4'hB: begin aluOp = ALUOP_CMP; IMM_MUX = 1'b1; imm = imm_sext; end
                    4'hD: begin aluOp = ALUOP_MOV; IMM_MUX = 1'b1; imm = imm_zext; write = 1'b1; end
                    4'hF: begin aluOp = ALUOP_LUI; IMM_MUX = 1'b1; imm = imm_zext; write = 1'b1; end
                    4'h8: begin
                        if (ext == 4'h0 || ext == 4'h1) begin
                            aluOp   = (ext == 4'h0) ? ALUOP_SLL : ALUOP_SRA;
                            IMM_MUX = 1'b1;
                            imm     = {12'h000, ir_q[3:0]};
                            write   = 1'b1;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    4'h4: begin
                        if (ext == 4'h0 || ext == 4'h4) begin
                            // pc advances only once the data access completes
                            state_d = S_MEM;
                            pc_d    = pc_q;
`ifdef CPU_CTRL_JAL_EN
                        end else if (ext == 4'h8) begin
                            write  = 1'b1;
                            WB_MUX = 2'b01;
                            pc_d   = dSrc;
`endif
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    4'hC: begin
                        if (branch_taken) begin
                            pc_d = pc_inc + imm_sext;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end

            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = dSrc;
                mem_we   = (ext == 4'h4);
                rSrc     = rs;
                rDst     = rd;
                if (mem_ack) begin
                    mem_data_d = mem_rdata;
                    pc_d       = pc_inc;
                    state_d    = (ext == 4'h4) ? S_FETCH : S_WB;
                end
            end

            S_WB: begin
                write   = 1'b1;
                WB_MUX  = 2'b11;
                rDst    = rd;
                rSrc    = rs;
                state_d = S_FETCH;
            end

            default: state_d = S_FETCH;
        endcase

        // Hold the control set idle while reset is asserted
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            write   = 1'b0;
            IMM_MUX = 1'b0;
            WB_MUX  = 2'b10;
            rSrc    = 4'h0;
            rDst    = 4'h0;
            aluOp   = ALUOP_NOP;
            imm     = 16'h0000;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: scenario tasks with a scoreboard
// queue of expected decode results, popped when the DUT reaches EXEC/MEM/WB.
module tb_cpu_ctrl_fsm;

    localparam logic [4:0] OP_AND = 5'h01;
    localparam logic [4:0] OP_ADD = 5'h05;
    localparam logic [4:0] OP_SUB = 5'h09;
    localparam logic [4:0] OP_CMP = 5'h0B;
    localparam logic [4:0] OP_MOV = 5'h0D;
    localparam logic [4:0] OP_LUI = 5'h0F;
    localparam logic [4:0] OP_SLL = 5'h10;
    localparam logic [4:0] OP_SRA = 5'h11;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [4:0]  psrOut;
    logic [15:0] dSrc;
    logic [15:0] dDst;
    logic        mem_req, mem_we, write, IMM_MUX, illegal;
    logic [15:0] mem_addr, mem_wdata, imm, pc1, mem_data;
    logic [1:0]  WB_MUX;
    logic [3:0]  rSrc, rDst;
    logic [4:0]  aluOp;

    always #5 clk = ~clk;

    cpu_ctrl_fsm #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .psrOut(psrOut), .dSrc(dSrc), .dDst(dDst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .write(write), .IMM_MUX(IMM_MUX), .WB_MUX(WB_MUX), .rSrc(rSrc), .rDst(rDst),
        .aluOp(aluOp), .imm(imm), .pc1(pc1), .mem_data(mem_data), .illegal(illegal)
    );

    typedef struct {
        logic [15:0] instr;
        logic        wr;
        logic        immmux;
        logic [4:0]  aluop;
        logic [15:0] imm;
        logic [3:0]  rdst;
        logic        ill;
        logic [15:0] next_pc;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_pc;

    function automatic exp_t mk(input logic [15:0] instr, input logic wr, input logic immmux,
                                input logic [4:0] aluop, input logic [15:0] immv,
                                input logic [3:0] rdst, input logic ill,
                                input logic [15:0] next_pc, input logic [15:0] data);
        exp_t e;
        e.instr = instr; e.wr = wr; e.immmux = immmux; e.aluop = aluop; e.imm = immv;
        e.rdst = rdst; e.ill = ill; e.next_pc = next_pc; e.data = data;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction on the fetch port after a number of wait cycles
    task automatic do_fetch(input logic [15:0] instr, input int waits);
        for (int i = 0; i < waits; i++) begin
            mem_ack = 1'b0;
            tick();
        end
        mem_rdata = instr;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h510A;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({mem_req, mem_we, write, IMM_MUX, illegal} !== 5'b0 || WB_MUX !== 2'b10 ||
                rSrc !== 4'h0 || rDst !== 4'h0 || aluOp !== 5'h00 || imm !== 16'h0 ||
                mem_data !== 16'h0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: req=%b we=%b wr=%b immmux=%b wbmux=%b rsrc=%h rdst=%h aluop=%h imm=%h ill=%b mdata=%h, want idle set",
                         i, mem_req, mem_we, write, IMM_MUX, WB_MUX, rSrc, rDst, aluOp, imm, illegal, mem_data);
            end
        end
        mem_ack = 1'b0; rst = 1'b0;
        #2;
        model_pc = 16'h0000;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== model_pc) begin
            errors++;
            $display("FAIL reset_release: req=%b addr=%h, want req=1 addr=%h", mem_req, mem_addr, model_pc);
        end
        $display("reset: released, first fetch addr=%h", mem_addr);
    endtask

    task automatic test_addi();
        exp_t e;
        sb.push_back(mk(16'h510A, 1'b1, 1'b1, OP_ADD, 16'h000A, 4'h1, 1'b0, model_pc + 16'd1, 16'h0));
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== model_pc) begin
                errors++;
                $display("FAIL addi_fetch_hold w%0d: req=%b addr=%h, want 1 %h", i, mem_req, mem_addr, model_pc);
            end
        end
        do_fetch(16'h510A, 0);
        e = sb.pop_front();
        checks++;
        if (write !== e.wr || IMM_MUX !== e.immmux || rDst !== e.rdst || imm !== e.imm ||
            aluOp !== e.aluop || illegal !== e.ill) begin
            errors++;
            $display("FAIL addi_exec: wr=%b immmux=%b rdst=%h imm=%h aluop=%h ill=%b, want %b %b %h %h %h %b",
                     write, IMM_MUX, rDst, imm, aluOp, illegal, e.wr, e.immmux, e.rdst, e.imm, e.aluop, e.ill);
        end
        checks++;
        if (pc1 !== model_pc + 16'd1) begin
            errors++;
            $display("FAIL addi_pc1: got %h want %h", pc1, model_pc + 16'd1);
        end
        tick();
        checks++;
        if (mem_addr !== e.next_pc || write !== 1'b0 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL addi_next: addr=%h wr=%b req=%b, want %h 0 1", mem_addr, write, mem_req, e.next_pc);
        end
        model_pc = e.next_pc;
        $display("addi: instr=%h imm=%h pc->%h", e.instr, imm, model_pc);
    endtask

    task automatic test_load();
        exp_t e;
        dSrc = 16'hFF00;
        sb.push_back(mk(16'h4302, 1'b1, 1'b0, 5'h00, 16'h0, 4'h3, 1'b0, model_pc + 16'd1, 16'h000A));
        do_fetch(16'h4302, 0);
        checks++;
        if (write !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL load_exec: wr=%b req=%b, want 0 0", write, mem_req);
        end
        mem_ack = 1'b1;  // no request outstanding here, must be ignored
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 16'hFF00 || mem_we !== 1'b0 || rDst !== 4'h3 || rSrc !== 4'h2) begin
                errors++;
                $display("FAIL load_mem c%0d: req=%b addr=%h we=%b rdst=%h rsrc=%h, want 1 ff00 0 3 2",
                         i, mem_req, mem_addr, mem_we, rDst, rSrc);
            end
            if (i == 0) tick();
        end
        mem_rdata = 16'h000A; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'hDEAD;
        e = sb.pop_front();
        checks++;
        if (write !== 1'b1 || WB_MUX !== 2'b11 || rDst !== e.rdst || mem_data !== e.data) begin
            errors++;
            $display("FAIL load_wb: wr=%b wbmux=%b rdst=%h mdata=%h, want 1 11 %h %h",
                     write, WB_MUX, rDst, mem_data, e.rdst, e.data);
        end
        tick();
        checks++;
        if (mem_addr !== e.next_pc || write !== 1'b0 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL load_next: addr=%h wr=%b req=%b, want %h 0 1", mem_addr, write, mem_req, e.next_pc);
        end
        model_pc = e.next_pc;
        $display("load: instr=%h data=%h pc->%h", e.instr, mem_data, model_pc);
    endtask

    task automatic test_stor();
        exp_t e;
        dSrc = 16'h1234; dDst = 16'h000A;
        sb.push_back(mk(16'h4142, 1'b0, 1'b0, 5'h00, 16'h0, 4'h1, 1'b0, model_pc + 16'd1, 16'h000A));
        do_fetch(16'h4142, 0);
        checks++;
        if (write !== 1'b0) begin
            errors++;
            $display("FAIL stor_exec: wr=%b want 0", write);
        end
        tick();
        e = sb.pop_front();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== e.data || mem_addr !== 16'h1234 || write !== 1'b0) begin
            errors++;
            $display("FAIL stor_mem: req=%b we=%b wdata=%h addr=%h wr=%b, want 1 1 %h 1234 0",
                     mem_req, mem_we, mem_wdata, mem_addr, write, e.data);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (mem_addr !== e.next_pc || write !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL stor_next: addr=%h wr=%b we=%b, want %h 0 0", mem_addr, write, mem_we, e.next_pc);
        end
        model_pc = e.next_pc;
        $display("stor: instr=%h pc->%h", e.instr, model_pc);
    endtask

    task automatic test_alu_ops();
        exp_t tbl[12];
        exp_t e;
        tbl[0]  = mk(16'h0215, 1'b1, 1'b0, OP_AND, 16'h0000, 4'h2, 1'b0, 16'h0, 16'h0);
        tbl[1]  = mk(16'h0557, 1'b1, 1'b0, OP_ADD, 16'h0000, 4'h5, 1'b0, 16'h0, 16'h0);
        tbl[2]  = mk(16'h0394, 1'b1, 1'b0, OP_SUB, 16'h0000, 4'h3, 1'b0, 16'h0, 16'h0);
        tbl[3]  = mk(16'h03B4, 1'b0, 1'b0, OP_CMP, 16'h0000, 4'h3, 1'b0, 16'h0, 16'h0);
        tbl[4]  = mk(16'h06D1, 1'b1, 1'b0, OP_MOV, 16'h0000, 4'h6, 1'b0, 16'h0, 16'h0);
        tbl[5]  = mk(16'h93F0, 1'b1, 1'b1, OP_SUB, 16'hFFF0, 4'h3, 1'b0, 16'h0, 16'h0);
        tbl[6]  = mk(16'h12F0, 1'b1, 1'b1, OP_AND, 16'h00F0, 4'h2, 1'b0, 16'h0, 16'h0);
        tbl[7]  = mk(16'hB180, 1'b0, 1'b1, OP_CMP, 16'hFF80, 4'h1, 1'b0, 16'h0, 16'h0);
        tbl[8]  = mk(16'hD480, 1'b1, 1'b1, OP_MOV, 16'h0080, 4'h4, 1'b0, 16'h0, 16'h0);
        tbl[9]  = mk(16'hF1AB, 1'b1, 1'b1, OP_LUI, 16'h00AB, 4'h1, 1'b0, 16'h0, 16'h0);
        tbl[10] = mk(16'h8207, 1'b1, 1'b1, OP_SLL, 16'h0007, 4'h2, 1'b0, 16'h0, 16'h0);
        tbl[11] = mk(16'h8211, 1'b1, 1'b1, OP_SRA, 16'h0001, 4'h2, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 12; i++) begin
            tbl[i].next_pc = model_pc + 16'd1;
            sb.push_back(tbl[i]);
            do_fetch(tbl[i].instr, i % 2);
            e = sb.pop_front();
            checks++;
            if (write !== e.wr || IMM_MUX !== e.immmux || aluOp !== e.aluop || rDst !== e.rdst ||
                rSrc !== e.instr[3:0] || illegal !== e.ill || (e.immmux && imm !== e.imm)) begin
                errors++;
                $display("FAIL alu_exec %h: wr=%b immmux=%b aluop=%h rdst=%h rsrc=%h ill=%b imm=%h, want %b %b %h %h %h %b %h",
                         e.instr, write, IMM_MUX, aluOp, rDst, rSrc, illegal, imm,
                         e.wr, e.immmux, e.aluop, e.rdst, e.instr[3:0], e.ill, e.imm);
            end
            tick();
            checks++;
            if (mem_addr !== e.next_pc || write !== 1'b0) begin
                errors++;
                $display("FAIL alu_next %h: addr=%h wr=%b, want %h 0", e.instr, mem_addr, write, e.next_pc);
            end
            model_pc = e.next_pc;
            $display("alu: instr=%h aluop=%h imm=%h pc->%h", e.instr, e.aluop, e.imm, model_pc);
        end
    endtask

    task automatic test_branch();
        logic [15:0] ins[6]  = '{16'hCE00, 16'hC0FE, 16'hCE00, 16'hC0FE, 16'hCEED, 16'hCE00};
        logic [4:0]  psr[6]  = '{5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        logic [15:0] tgt[6]  = '{16'h0010, 16'h000F, 16'h0010, 16'h0011, 16'hFFFF, 16'h0000};
        logic [15:0] cins[11] = '{16'hC103, 16'hC103, 16'hC403, 16'hC403, 16'hC503, 16'hC503,
                                  16'hCC03, 16'hCC03, 16'hCD03, 16'hC203, 16'hCF03};
        logic [4:0]  cpsr[11] = '{5'b00000, 5'b01000, 5'b00000, 5'b10000, 5'b10000, 5'b00000,
                                  5'b00010, 5'b00000, 5'b00010, 5'b11111, 5'b11111};
        logic        ctk[11]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_t e;
        for (int i = 0; i < 17; i++) begin
            logic [15:0] instr;
            logic [15:0] np;
            if (i < 6) begin
                instr = ins[i]; psrOut = psr[i]; np = tgt[i];
            end else begin
                instr = cins[i-6]; psrOut = cpsr[i-6];
                np = ctk[i-6] ? model_pc + 16'd4 : model_pc + 16'd1;
            end
            sb.push_back(mk(instr, 1'b0, 1'b0, 5'h00, 16'h0, 4'h0, 1'b0, np, 16'h0));
            do_fetch(instr, 0);
            e = sb.pop_front();
            checks++;
            if (write !== 1'b0 || illegal !== 1'b0) begin
                errors++;
                $display("FAIL br_exec %h: wr=%b ill=%b, want 0 0", e.instr, write, illegal);
            end
            tick();
            checks++;
            if (mem_addr !== e.next_pc || mem_req !== 1'b1) begin
                errors++;
                $display("FAIL br_target %h@%h psr=%b: addr=%h, want %h", e.instr, model_pc, psrOut, mem_addr, e.next_pc);
            end
            $display("branch: instr=%h pc=%h psr=%b -> %h", e.instr, model_pc, psrOut, e.next_pc);
            model_pc = e.next_pc;
        end
        psrOut = 5'b00000;
    endtask

    task automatic test_illegal();
`ifdef CPU_CTRL_JAL_EN
        logic [15:0] ins[4] = '{16'h7000, 16'h0021, 16'h8221, 16'h4010};
        int n = 4;
`else
        logic [15:0] ins[5] = '{16'h7000, 16'h0021, 16'h8221, 16'h4010, 16'h4080};
        int n = 5;
`endif
        exp_t e;
        for (int i = 0; i < n; i++) begin
            sb.push_back(mk(ins[i], 1'b0, 1'b0, 5'h00, 16'h0, 4'h0, 1'b1, model_pc + 16'd1, 16'h0));
            do_fetch(ins[i], 0);
            e = sb.pop_front();
            checks++;
            if (illegal !== e.ill || write !== 1'b0) begin
                errors++;
                $display("FAIL illegal_exec %h: ill=%b wr=%b, want 1 0", e.instr, illegal, write);
            end
            tick();
            checks++;
            if (illegal !== 1'b0 || mem_addr !== e.next_pc || write !== 1'b0) begin
                errors++;
                $display("FAIL illegal_next %h: ill=%b addr=%h wr=%b, want 0 %h 0", e.instr, illegal, mem_addr, write, e.next_pc);
            end
            model_pc = e.next_pc;
            $display("illegal: instr=%h pc->%h", e.instr, model_pc);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            logic [7:0]  k  = 8'($urandom_range(0, 255));
            logic [3:0]  r  = 4'($urandom_range(0, 15));
            logic [15:0] instr = {4'h5, r, k};
            sb.push_back(mk(instr, 1'b1, 1'b1, OP_ADD, {{8{k[7]}}, k}, r, 1'b0, model_pc + 16'd1, 16'h0));
            do_fetch(instr, 0);
            e = sb.pop_front();
            checks++;
            if (write !== 1'b1 || IMM_MUX !== 1'b1 || aluOp !== e.aluop || imm !== e.imm || rDst !== e.rdst) begin
                errors++;
                $display("FAIL b2b_exec %h: wr=%b immmux=%b aluop=%h imm=%h rdst=%h, want 1 1 %h %h %h",
                         e.instr, write, IMM_MUX, aluOp, imm, rDst, e.aluop, e.imm, e.rdst);
            end
            tick();
            checks++;
            if (mem_addr !== e.next_pc || write !== 1'b0) begin
                errors++;
                $display("FAIL b2b_next %h: addr=%h wr=%b, want %h 0", e.instr, mem_addr, write, e.next_pc);
            end
            model_pc = e.next_pc;
            $display("b2b: instr=%h imm=%h pc->%h", e.instr, e.imm, model_pc);
        end
    endtask

    task automatic test_reset_mid_mem();
        dSrc = 16'h4444;
        do_fetch(16'h4302, 0);
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h4444) begin
            errors++;
            $display("FAIL rstmem_inmem: req=%b addr=%h, want 1 4444", mem_req, mem_addr);
        end
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || write !== 1'b0 || mem_data !== 16'h0000) begin
            errors++;
            $display("FAIL rstmem_reset: req=%b wr=%b mdata=%h, want 0 0 0000", mem_req, write, mem_data);
        end
        rst = 1'b0;
        #2;
        model_pc = 16'h0000;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== model_pc || write !== 1'b0) begin
            errors++;
            $display("FAIL rstmem_fetch: req=%b addr=%h wr=%b, want 1 %h 0", mem_req, mem_addr, write, model_pc);
        end
        $display("reset_mid_mem: fetch restarts at %h", mem_addr);
    endtask

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0000;
        psrOut = 5'b00000; dSrc = 16'h0000; dDst = 16'h0000;
        model_pc = 16'h0000;
        test_reset();
        test_addi();
        test_load();
        test_stor();
        test_alu_ops();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_reset_mid_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
